// File: rtl/synch_3ff_if.sv
// Signal bundle for the single-bit CDC synchronizer: the asynchronous level in,
// the synchronized level and its rise/fall strobes out.
interface synch_3ff_if;
    logic ASYNC_IN;
    logic SYNC_OUT;
    logic SYNC_RISE;
    logic SYNC_FALL;

    modport master (
        output ASYNC_IN,
        input  SYNC_OUT,
        input  SYNC_RISE,
        input  SYNC_FALL
    );

    modport slave (
        input  ASYNC_IN,
        output SYNC_OUT,
        output SYNC_RISE,
        output SYNC_FALL
    );
endinterface

// File: rtl/synch_3ff.sv
// Single-bit level synchronizer: STAGES-deep flop chain into the CLK domain,
// plus one-cycle rise/fall strobes derived from the synchronized level.
module synch_3ff #(
    parameter int unsigned STAGES  = 3,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    synch_3ff_if.slave  bus
);

    if ((STAGES < 2) || (STAGES > 8)) begin : g_stages_check
        $error("synch_3ff: STAGES must be in 2..8");
    end

    // Chain flops must stay discrete, unretimed and out of SRL/RAM inference.
    (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_retime = "true" *)
    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], bus.ASYNC_IN};
        prev_d  = stage_q[STAGES-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
        end
    end

    // Strobes are decoded from two flops, so they are glitch-free in the CLK domain.
    assign bus.SYNC_OUT  = stage_q[STAGES-1];
    assign bus.SYNC_RISE = stage_q[STAGES-1] & ~prev_q;
    assign bus.SYNC_FALL = ~stage_q[STAGES-1] & prev_q;

endmodule

// File: tb/tb_synch_3ff.sv
// Directed bench for synch_3ff at STAGES = 2, 3 and 5, with a per-instance
// latency queue as the scoreboard for level and strobe outputs.
module tb_synch_3ff;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic async_in = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    localparam int NDUT = 3;
    int   st [NDUT] = '{2, 3, 5};
    logic mq [NDUT][$];
    logic prevq [NDUT];

    synch_3ff_if bus2 ();
    synch_3ff_if bus3 ();
    synch_3ff_if bus5 ();

    assign bus2.ASYNC_IN = async_in;
    assign bus3.ASYNC_IN = async_in;
    assign bus5.ASYNC_IN = async_in;

    synch_3ff #(.STAGES(2), .RST_VAL(1'b0)) u_dut2 (.CLK(CLK), .RST(RST), .bus(bus2));
    synch_3ff #(.STAGES(3), .RST_VAL(1'b0)) u_dut3 (.CLK(CLK), .RST(RST), .bus(bus3));
    synch_3ff #(.STAGES(5), .RST_VAL(1'b0)) u_dut5 (.CLK(CLK), .RST(RST), .bus(bus5));

    logic outs [NDUT];
    logic rise [NDUT];
    logic fall [NDUT];
    assign outs[0] = bus2.SYNC_OUT;
    assign outs[1] = bus3.SYNC_OUT;
    assign outs[2] = bus5.SYNC_OUT;
    assign rise[0] = bus2.SYNC_RISE;
    assign rise[1] = bus3.SYNC_RISE;
    assign rise[2] = bus5.SYNC_RISE;
    assign fall[0] = bus2.SYNC_FALL;
    assign fall[1] = bus3.SYNC_FALL;
    assign fall[2] = bus5.SYNC_FALL;

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue holds the STAGES-1 captures still in flight; the front is the next SYNC_OUT.
    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            mq[d].delete();
            for (int k = 0; k < st[d] - 1; k++) mq[d].push_back(1'b0);
            prevq[d] = 1'b0;
        end
    endtask

    task automatic at(input int t);
        #(t - $time);
    endtask

    // Scoreboard: push the value captured at each live edge, pop the expected output.
    always @(posedge CLK) begin
        logic c;
        logic e;
        if (RST) begin
            #1;
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("rst_out_s%0d", st[d]), outs[d], 1'b0);
                check($sformatf("rst_rise_s%0d", st[d]), rise[d], 1'b0);
                check($sformatf("rst_fall_s%0d", st[d]), fall[d], 1'b0);
            end
        end else begin
            c = async_in;
            #1;
            for (int d = 0; d < NDUT; d++) begin
                e = mq[d].pop_front();
                mq[d].push_back(c);
                check($sformatf("out_s%0d", st[d]), outs[d], e);
                check($sformatf("rise_s%0d", st[d]), rise[d], e & ~prevq[d]);
                check($sformatf("fall_s%0d", st[d]), fall[d], ~e & prevq[d]);
                prevq[d] = e;
            end
        end
    end

    initial begin
        // Reset with ASYNC_IN high: output held low until three edges after release.
        model_reset();
        at(10);
        check("por_out_s3", bus3.SYNC_OUT, 1'b0);
        check("por_rise_s3", bus3.SYNC_RISE, 1'b0);
        at(20);
        RST = 1'b0;
        at(40);
        check("first_rise_pre_s3", bus3.SYNC_OUT, 1'b0);
        at(50);
        check("first_rise_out_s3", bus3.SYNC_OUT, 1'b1);
        check("first_rise_strobe_s3", bus3.SYNC_RISE, 1'b1);

        // One-edge low pulse: captured only by the 55 ns edge.
        async_in = 1'b0;
        at(60);
        check("first_rise_done_s3", bus3.SYNC_RISE, 1'b0);
        async_in = 1'b1;
        at(80);
        check("glitch_out_s3", bus3.SYNC_OUT, 1'b0);
        check("glitch_fall_s3", bus3.SYNC_FALL, 1'b1);
        at(90);
        check("glitch_back_s3", bus3.SYNC_OUT, 1'b1);
        check("glitch_rise_s3", bus3.SYNC_RISE, 1'b1);

        // 50 ns low: five captures.
        at(100); async_in = 1'b0;
        at(150); async_in = 1'b1;

        // Rapid toggles of 15/12/18 ns.
        at(202); async_in = 1'b0;
        at(217); async_in = 1'b1;
        at(229); async_in = 1'b0;
        at(247); async_in = 1'b1;

        // Mid-operation reset: flush is immediate, input activity during reset is ignored.
        at(302);
        check("pre_rst_out_s2", bus2.SYNC_OUT, 1'b1);
        check("pre_rst_out_s3", bus3.SYNC_OUT, 1'b1);
        check("pre_rst_out_s5", bus5.SYNC_OUT, 1'b1);
        RST = 1'b1;
        model_reset();
        at(303);
        check("async_rst_out_s2", bus2.SYNC_OUT, 1'b0);
        check("async_rst_out_s3", bus3.SYNC_OUT, 1'b0);
        check("async_rst_out_s5", bus5.SYNC_OUT, 1'b0);
        check("async_rst_fall_s3", bus3.SYNC_FALL, 1'b0);
        at(308); async_in = 1'b0;
        at(316); async_in = 1'b1;
        at(322); RST = 1'b0;
        at(340);
        check("rst_recover_pre_s3", bus3.SYNC_OUT, 1'b0);
        at(350);
        check("rst_recover_out_s3", bus3.SYNC_OUT, 1'b1);
        check("rst_recover_rise_s3", bus3.SYNC_RISE, 1'b1);

        // 7 ns low pulse between edges 395 and 405: never sampled.
        at(397); async_in = 1'b0;
        at(404); async_in = 1'b1;
        at(430);
        check("short_pulse_out_s3", bus3.SYNC_OUT, 1'b1);

        // 100 ns low: ten captures.
        at(450); async_in = 1'b0;
        at(550); async_in = 1'b1;

        at(700);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/synch_3ff.md
Name: synch_3ff

Overview:
Single-bit clock-domain-crossing synchronizer. It brings an asynchronous level signal (external pin, other clock domain) into the CLK domain through a chain of flip-flops, 3 stages by default. It also provides single-cycle rise/fall strobes derived from the synchronized level. It sits at every asynchronous input boundary of the design.

Parameters:
STAGES, 3, number of synchronizer flip-flops in the chain; legal range 2..8; values outside the range are a elaboration-time error.
RST_VAL, 1'b0, value loaded into every stage and the edge-detect history register on reset.

Ports:
CLK  input  1  system clock; all flops on the rising edge.
RST  input  1  reset, asynchronous assert, active-high; release must be synchronous to CLK at system level.
ASYNC_IN  input  1  asynchronous level input; no timing relationship to CLK.
SYNC_OUT  output  1  synchronized level; equal to the last stage of the chain.
SYNC_RISE  output  1  one-CLK-cycle pulse when SYNC_OUT goes 0->1.
SYNC_FALL  output  1  one-CLK-cycle pulse when SYNC_OUT goes 1->0.

Behaviour:
- Interface: one clock (CLK). Reset (RST) is asynchronous and active-high.
- Chain: on each CLK rising edge, stage[0] <= ASYNC_IN and stage[i] <= stage[i-1]. SYNC_OUT = stage[STAGES-1], driven directly from the flop with no combinational logic after it.
- Latency: a value sampled at rising edge n appears on SYNC_OUT after edge n+STAGES-1 (edge n+2 for the default). Total delay from an ASYNC_IN change is 2 to 3 CLK periods, depending on phase.
- Stage 0 is the only flop that sees ASYNC_IN. ASYNC_IN must not fan out anywhere else. No logic between stages.
- Mark the chain flops as a synchronizer: ASYNC_REG attribute or tool equivalent, no retiming, no shift-register extraction into SRL/RAM.
- Reset: while RST=1, all stages and the edge history register are forced to RST_VAL immediately, without waiting for a clock edge.
  - SYNC_OUT=RST_VAL (0) and SYNC_RISE=SYNC_FALL=0 during reset.
  - After release, SYNC_OUT follows ASYNC_IN with normal latency. If ASYNC_IN=1 at release, SYNC_OUT rises STAGES edges after release.
- Edge detect: a history register prev <= SYNC_OUT each edge.
  - SYNC_RISE = SYNC_OUT & ~prev.
  - SYNC_FALL = ~SYNC_OUT & prev.
  - Both are registered-path derived, each exactly one cycle wide, and never high together.
  - The first rise after reset with ASYNC_IN=1 produces one SYNC_RISE pulse.
- Reset mid-operation: the chain is flushed to RST_VAL. Any in-flight transition is discarded and no edge strobe fires during reset.
- Pulse filtering:
  - An input pulse that contains no CLK rising edge is not captured and produces no output change.
  - A pulse spanning k rising edges appears on SYNC_OUT as k cycles at the same level.
  - No pulse stretching or debouncing is performed.
- Metastability: stage 0 may go metastable. Downstream stages give resolution time. Output order of transitions is preserved.

Test Plan:
- Clock 10 ns (rising at 5, 15, ...), RST=1 for 0-20 ns with ASYNC_IN=1 -> SYNC_OUT=0 during reset, rises at edge 45 ns (third edge after release at 20), SYNC_RISE high for the 45-55 ns cycle.
- ASYNC_IN 1->0 at 50 ns, back to 1 at 60 ns (captured only by edge 55) -> SYNC_OUT=0 for exactly one cycle (75-85 ns), SYNC_FALL at 75 ns, SYNC_RISE at 85 ns.
- ASYNC_IN low for 50 ns -> SYNC_OUT low for 5 cycles, with a 2-edge delay after the first capturing edge.
- Rapid toggles 15/12/18 ns -> SYNC_OUT reproduces the edge-sampled sequence delayed by 2 edges; no simultaneous SYNC_RISE/SYNC_FALL.
- Assert RST for 20 ns while SYNC_OUT=1 -> SYNC_OUT drops to 0 immediately (before the next edge); after release it returns to 1 on the third edge with one SYNC_RISE.
- 7 ns low pulse placed between rising edges -> SYNC_OUT stays 1 and no strobes fire. Then a 100 ns low -> SYNC_OUT low for 10 cycles. Repeat with STAGES=2 and 5 to confirm latency = STAGES-1 edges after capture.
